// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: synchronises and debounces the tank and climate
// sensors, checks the level probes for consistency, runs the inlet valve
// as a hysteresis latch, and sequences sprinkler/drip runs with a
// mandatory cooldown after each run.
module irrigation_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IRRIG_CYCLES    = 16,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       high,
    input  logic       middle,
    input  logic       low,
    input  logic       soil_wet,
    input  logic       air_wet,
    input  logic       temp_high,
    output logic       valve_in,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic       alarm,
    output logic       error,
    output logic [2:0] state
);

    // The run timer must hold the larger of the two reload values.
    localparam int MAX_CYCLES = (IRRIG_CYCLES > COOLDOWN_CYCLES) ? IRRIG_CYCLES : COOLDOWN_CYCLES;
    localparam int TIMER_W    = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] IRRIG_LOAD    = TIMER_W'(IRRIG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOLDOWN_LOAD = TIMER_W'(COOLDOWN_CYCLES - 1);

    // Debounce counter counts differing samples up to DEBOUNCE_CYCLES-1.
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // Settling window after reset covers synchroniser plus debouncer depth.
    localparam int SETTLE_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPRINKLE = 3'd1,
        DRIP     = 3'd2,
        COOLDOWN = 3'd3,
        FAULT    = 3'd4
    } state_t;

    // Sensor bit order: 0 high, 1 middle, 2 low, 3 soil_wet, 4 air_wet, 5 temp_high.
    logic [5:0]       raw;
    logic [5:0]       sync_a;
    logic [5:0]       sync_b;
    logic [5:0]       filt;
    logic [DEB_W-1:0] deb_cnt [6];

    logic                high_filt;
    logic                middle_filt;
    logic                low_filt;
    logic                soil_filt;
    logic                air_filt;
    logic                temp_filt;
    logic                level_error;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settled;
    logic                request;
    logic                sprinkle_mode;

    state_t               fsm_state;
    state_t               fsm_next;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_next;

    assign raw = {temp_high, air_wet, soil_wet, low, middle, high};

    assign high_filt   = filt[0];
    assign middle_filt = filt[1];
    assign low_filt    = filt[2];
    assign soil_filt   = filt[3];
    assign air_filt    = filt[4];
    assign temp_filt   = filt[5];

    // Probes are nested: a higher probe wet while a lower one is dry is impossible.
    assign level_error = (high_filt & ~middle_filt) | (middle_filt & ~low_filt) | (high_filt & ~low_filt);

    // Irrigation is only requested once the filters hold real sensor data.
    assign request       = settled & ~soil_filt & ~alarm;
    assign sprinkle_mode = middle_filt & ~air_filt & ~temp_filt;

    assign state = fsm_state;

    // Two-flop synchroniser for every asynchronous sensor input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Per-bit debouncer: the filtered value flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < 6; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync_b[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Settling counter keeps valves shut until the filters have accepted real inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            if (settle_cnt == SETTLE_LAST) begin
                settled <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
            end
        end
    end

    // Registered level-error and alarm flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
            alarm <= 1'b0;
        end else begin
            error <= level_error;
            alarm <= level_error | ~low_filt;
        end
    end

    // Inlet valve hysteresis: open below middle, close at high; closing wins on any conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valve_in <= 1'b0;
        end else if (settled) begin
            if (high_filt | level_error) begin
                valve_in <= 1'b0;
            end else if (~middle_filt & ~level_error) begin
                valve_in <= 1'b1;
            end
        end
    end

    // State, timer and Moore valve outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state       <= IDLE;
            timer           <= '0;
            valve_sprinkler <= 1'b0;
            valve_drip      <= 1'b0;
        end else begin
            fsm_state       <= fsm_next;
            timer           <= timer_next;
            valve_sprinkler <= (fsm_next == SPRINKLE);
            valve_drip      <= (fsm_next == DRIP);
        end
    end

    // Next-state and timer logic; an active alarm overrides every other transition.
    always_comb begin
        fsm_next   = fsm_state;
        timer_next = timer;
        if (alarm) begin
            fsm_next   = FAULT;
            timer_next = '0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (request) begin
                        timer_next = IRRIG_LOAD;
                        fsm_next   = sprinkle_mode ? SPRINKLE : DRIP;
                    end
                end
                SPRINKLE, DRIP: begin
                    if ((timer == '0) || soil_filt) begin
                        fsm_next   = COOLDOWN;
                        timer_next = COOLDOWN_LOAD;
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                        if ((fsm_state == SPRINKLE) && !middle_filt) begin
                            fsm_next = DRIP;
                        end
                    end
                end
                COOLDOWN: begin
                    if (timer == '0) begin
                        fsm_next = IDLE;
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                    end
                end
                FAULT: begin
                    fsm_next   = COOLDOWN;
                    timer_next = COOLDOWN_LOAD;
                end
                default: begin
                    fsm_next   = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed testbench for irrigation_scheduler with hand-computed expectations.
module tb_irrigation_scheduler;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SPRINKLE = 3'd1;
    localparam logic [2:0] S_DRIP     = 3'd2;
    localparam logic [2:0] S_COOLDOWN = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       high;
    logic       middle;
    logic       low;
    logic       soil_wet;
    logic       air_wet;
    logic       temp_high;
    logic       valve_in;
    logic       valve_sprinkler;
    logic       valve_drip;
    logic       alarm;
    logic       error;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    irrigation_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .IRRIG_CYCLES(16),
        .COOLDOWN_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .high(high),
        .middle(middle),
        .low(low),
        .soil_wet(soil_wet),
        .air_wet(air_wet),
        .temp_high(temp_high),
        .valve_in(valve_in),
        .valve_sprinkler(valve_sprinkler),
        .valve_drip(valve_drip),
        .alarm(alarm),
        .error(error),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic h, input logic m, input logic l,
                                  input logic soil, input logic air, input logic temp);
        high      = h;
        middle    = m;
        low       = l;
        soil_wet  = soil;
        air_wet   = air;
        temp_high = temp;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            tick(1);
            n++;
        end
        check_output(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic measure_state(input logic [2:0] s, input int budget,
                                 output int n, output int n_spr, output int n_drip);
        n      = 0;
        n_spr  = 0;
        n_drip = 0;
        while (state === s && n < budget) begin
            n++;
            if (valve_sprinkler === 1'b1) n_spr++;
            if (valve_drip === 1'b1) n_drip++;
            tick(1);
        end
    endtask

    initial begin
        int n;
        int n_spr;
        int n_drip;
        int opened;

        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        check_output("reset_state", {29'd0, state}, 32'd0);
        check_output("reset_valve_in", {31'd0, valve_in}, 32'd0);
        check_output("reset_valve_sprinkler", {31'd0, valve_sprinkler}, 32'd0);
        check_output("reset_valve_drip", {31'd0, valve_drip}, 32'd0);
        check_output("reset_alarm", {31'd0, alarm}, 32'd0);
        check_output("reset_error", {31'd0, error}, 32'd0);

        rst_n = 1'b1;
        opened = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if ((valve_in | valve_sprinkler | valve_drip) === 1'b1) opened++;
        end
        check_output("startup_no_valve", opened, 0);

        wait_state(S_SPRINKLE, 60, "first_sprinkle_reached");
        measure_state(S_SPRINKLE, 40, n, n_spr, n_drip);
        check_output("sprinkle_len", n, 16);
        check_output("sprinkle_valve_cycles", n_spr, 16);
        check_output("sprinkle_drip_cycles", n_drip, 0);
        check_output("after_sprinkle_cooldown", {29'd0, state}, {29'd0, S_COOLDOWN});
        measure_state(S_COOLDOWN, 40, n, n_spr, n_drip);
        check_output("cooldown_len", n, 8);
        check_output("cooldown_valves", n_spr + n_drip, 0);
        check_output("after_cooldown_idle", {29'd0, state}, {29'd0, S_IDLE});
        measure_state(S_IDLE, 40, n, n_spr, n_drip);
        check_output("idle_len", n, 1);
        check_output("second_run_sprinkle", {29'd0, state}, {29'd0, S_SPRINKLE});
        check_output("second_run_valve", {31'd0, valve_sprinkler}, 32'd1);

        tick(2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(6);
        check_output("middle_drop_still_sprinkle", {29'd0, state}, {29'd0, S_SPRINKLE});
        tick(1);
        check_output("middle_drop_drip", {29'd0, state}, {29'd0, S_DRIP});
        check_output("middle_drop_valve_drip", {31'd0, valve_drip}, 32'd1);
        check_output("middle_drop_valve_sprinkler", {31'd0, valve_sprinkler}, 32'd0);
        check_output("middle_drop_valve_in", {31'd0, valve_in}, 32'd1);
        measure_state(S_DRIP, 40, n, n_spr, n_drip);
        check_output("middle_drop_remaining", n, 7);
        check_output("middle_drop_to_cooldown", {29'd0, state}, {29'd0, S_COOLDOWN});
        check_output("middle_drop_valve_in_held", {31'd0, valve_in}, 32'd1);

        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_state(S_DRIP, 30, "hot_drip_reached");
        check_output("hot_drip_valve_in_closed", {31'd0, valve_in}, 32'd0);
        check_output("hot_drip_no_sprinkler", {31'd0, valve_sprinkler}, 32'd0);
        tick(3);
        soil_wet = 1'b1;
        tick(2);
        soil_wet = 1'b0;
        measure_state(S_DRIP, 40, n, n_spr, n_drip);
        check_output("glitch_drip_remaining", n, 11);
        check_output("glitch_drip_valve_cycles", n_drip, 11);
        check_output("glitch_sprinkler_cycles", n_spr, 0);
        check_output("glitch_then_cooldown", {29'd0, state}, {29'd0, S_COOLDOWN});

        wait_state(S_DRIP, 20, "fault_run_drip");
        middle = 1'b0;
        tick(6);
        check_output("fault_alarm_not_yet", {31'd0, alarm}, 32'd0);
        check_output("fault_state_not_yet", {29'd0, state}, {29'd0, S_DRIP});
        tick(1);
        check_output("fault_error", {31'd0, error}, 32'd1);
        check_output("fault_alarm", {31'd0, alarm}, 32'd1);
        tick(1);
        check_output("fault_state", {29'd0, state}, {29'd0, S_FAULT});
        check_output("fault_valve_drip", {31'd0, valve_drip}, 32'd0);
        check_output("fault_valve_sprinkler", {31'd0, valve_sprinkler}, 32'd0);
        check_output("fault_valve_in", {31'd0, valve_in}, 32'd0);
        tick(3);
        check_output("fault_held", {29'd0, state}, {29'd0, S_FAULT});
        middle = 1'b1;
        tick(8);
        check_output("fault_cleared_cooldown", {29'd0, state}, {29'd0, S_COOLDOWN});
        check_output("fault_cleared_error", {31'd0, error}, 32'd0);
        check_output("fault_cleared_alarm", {31'd0, alarm}, 32'd0);
        measure_state(S_COOLDOWN, 40, n, n_spr, n_drip);
        check_output("fault_cooldown_len", n, 8);
        check_output("fault_then_idle", {29'd0, state}, {29'd0, S_IDLE});

        wait_state(S_DRIP, 5, "final_drip_reached");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(7);
        check_output("final_drip_held", {29'd0, state}, {29'd0, S_DRIP});
        check_output("final_valve_in_open", {31'd0, valve_in}, 32'd1);
        check_output("final_valve_drip_open", {31'd0, valve_drip}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_state", {29'd0, state}, {29'd0, S_IDLE});
        check_output("async_reset_valve_drip", {31'd0, valve_drip}, 32'd0);
        check_output("async_reset_valve_in", {31'd0, valve_in}, 32'd0);
        check_output("async_reset_valve_sprinkler", {31'd0, valve_sprinkler}, 32'd0);
        check_output("async_reset_alarm", {31'd0, alarm}, 32'd0);
        check_output("async_reset_error", {31'd0, error}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical synchronized samples required before a sensor value is accepted.
REQ-002 Parameter IRRIG_CYCLES, default 16: maximum clock cycles a single irrigation run may last.
REQ-003 Parameter COOLDOWN_CYCLES, default 8: clock cycles of mandatory rest after any irrigation run.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active low.
REQ-007 high, middle, low  input  1 each  tank level probes; 1 = water at that level.
REQ-008 soil_wet  input  1  1 = soil humid, no irrigation needed.
REQ-009 air_wet  input  1  1 = air humid.
REQ-010 temp_high  input  1  1 = temperature above threshold.
REQ-011 valve_in  output  1  tank inlet valve, 1 = open.
REQ-012 valve_sprinkler  output  1  sprinkler valve, 1 = open.
REQ-013 valve_drip  output  1  drip valve, 1 = open.
REQ-014 alarm  output  1  low-water or sensor-fault alarm.
REQ-015 error  output  1  inconsistent level probes.
REQ-016 state  output  3  FSM state code: IDLE=0, SPRINKLE=1, DRIP=2, COOLDOWN=3, FAULT=4.

Function
REQ-017 Each of the six sensor inputs SHALL pass through a 2-flop synchronizer, then a debouncer; the filtered value SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-018 Filtered values SHALL reset to 0; all downstream logic SHALL use only filtered values.
REQ-019 error SHALL be registered and equal (high & ~middle) | (middle & ~low) | (high & ~low) on filtered probes.
REQ-020 alarm SHALL be registered and equal error | ~low.
REQ-021 valve_in SHALL be a hysteresis latch: set when ~middle & ~error, cleared when high | error; otherwise held.
REQ-022 Irrigation request SHALL be ~soil_wet & ~alarm.
REQ-023 Mode select: SPRINKLE when middle & ~air_wet & ~temp_high; otherwise DRIP.
REQ-024 IDLE: on request, load run timer with IRRIG_CYCLES-1 and go to the selected mode; else stay.
REQ-025 SPRINKLE/DRIP: decrement timer each cycle; go to COOLDOWN when timer reaches 0 or soil_wet becomes 1.
REQ-026 SPRINKLE SHALL go to DRIP, keeping the timer, when middle falls to 0 and no other exit condition holds.
REQ-027 COOLDOWN: load timer with COOLDOWN_CYCLES-1 on entry, decrement each cycle, return to IDLE at 0; requests are ignored.
REQ-028 From any state, alarm=1 SHALL force FAULT next cycle, taking priority over all other transitions.
REQ-029 FAULT: all irrigation valves closed; go to COOLDOWN when alarm=0.
REQ-030 valve_sprinkler=1 only in SPRINKLE and valve_drip=1 only in DRIP, both registered Moore outputs; both SHALL never be 1 at once.
REQ-031 Timer width SHALL be clog2 of max(IRRIG_CYCLES, COOLDOWN_CYCLES); timer SHALL not underflow.

Reset
REQ-032 While rst_n=0: state=IDLE, timer=0, synchronizers and debouncers 0, all outputs 0.
REQ-033 Reset asserted mid-run SHALL close all valves immediately, without waiting for a clock edge.
REQ-034 After release, no valve SHALL open before the debouncer has accepted inputs, at least DEBOUNCE_CYCLES+2 cycles.

Verification
REQ-035 Inputs high=middle=low=1, soil_wet=0, air_wet=0, temp_high=0 -> SPRINKLE, valve_sprinkler=1 for exactly 16 cycles, then COOLDOWN 8 cycles, then IDLE, then a new run.
REQ-036 Same as REQ-035 with temp_high=1 -> DRIP, valve_drip=1 for 16 cycles; valve_sprinkler stays 0.
REQ-037 middle drops to 0 during SPRINKLE -> DRIP within DEBOUNCE_CYCLES+3 cycles, remaining run time preserved, valve_in=1.
REQ-038 high=1, middle=0, low=1 -> error=1, alarm=1, state=FAULT, all valves 0; restore a valid pattern -> COOLDOWN, then IDLE.
REQ-039 A 2-cycle glitch on soil_wet during a run -> no state change.
REQ-040 rst_n pulled low mid-DRIP -> all outputs 0 asynchronously, state=IDLE.
